// File: rtl/vital_level_tracker.sv
// vital_level_tracker: saturating energy/stress/pleasure counters updated on a
// prescaled tick and by stimulus pulses. It also decodes the 2-bit indicators and
// raises a sticky starvation death flag.
module vital_level_tracker #(
    parameter int W          = 8,
    parameter int TICK_DIV   = 16,
    parameter int EN_INIT    = 192,
    parameter int FEED_STEP  = 32,
    parameter int ST_STEP    = 16,
    parameter int DEAD_TICKS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_inc,
    input  logic         en_dec,
    input  logic         st_dec,
    input  logic         pl_inc,
    input  logic         feed,
    input  logic         stress_evt,
    output logic [W-1:0] energy_level,
    output logic [W-1:0] stress_level,
    output logic [W-1:0] pleasure_level,
    output logic [1:0]   energy_indicator,
    output logic [1:0]   stress_indicator,
    output logic         dead,
    output logic         tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(DEAD_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(DEAD_TICKS);

    // Deltas are summed two bits wider than a level, so both underflow below zero
    // and overflow above 2^W-1 stay visible before the clamp.
    typedef logic signed [W+1:0] sw_t;
    localparam sw_t FEED_D = sw_t'(FEED_STEP);
    localparam sw_t ST_D   = sw_t'(ST_STEP);
    localparam sw_t ONE    = sw_t'(1);

    logic [PW-1:0] presc;
    logic [SW-1:0] starve;
    sw_t           en_delta;
    sw_t           st_delta;
    sw_t           pl_delta;

    // Adds a signed delta to a level and clamps the result to [0, 2^W-1].
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] lvl, input sw_t d);
        sw_t s;
        s = sw_t'({2'b00, lvl}) + d;
        if (s[W+1])
            return '0;
        else if (s[W])
            return '1;
        else
            return s[W-1:0];
    endfunction

    // Prescaler wraps at TICK_DIV-1. The tick is registered, so it is high in the
    // cycle after the wrap. This puts the first tick TICK_DIV cycles after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (presc == PRE_LAST);
            presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
        end
    end

    // Net per-cycle deltas: pulses always apply, rate controls only on tick.
    always_comb begin
        en_delta = '0;
        st_delta = '0;
        pl_delta = '0;
        if (feed)                        en_delta = en_delta + FEED_D;
        if (tick && en_inc && !en_dec)   en_delta = en_delta + ONE;
        if (tick && en_dec && !en_inc)   en_delta = en_delta - ONE;
        if (stress_evt)                  st_delta = st_delta + ST_D;
        if (tick && st_dec)              st_delta = st_delta - ONE;
        if (tick)                        pl_delta = pl_inc ? ONE : -ONE;
    end

    // Level registers; everything freezes once dead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            energy_level   <= W'(EN_INIT);
            stress_level   <= '0;
            pleasure_level <= '0;
        end else if (!dead) begin
            energy_level   <= sat_add(energy_level, en_delta);
            stress_level   <= sat_add(stress_level, st_delta);
            pleasure_level <= sat_add(pleasure_level, pl_delta);
        end
    end

    // Starvation counter: counts ticks that see energy==0 before the update,
    // clears as soon as energy is non-zero, and saturates at DEAD_TICKS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve <= '0;
        else if (!dead) begin
            if (energy_level != '0)
                starve <= '0;
            else if (tick && starve != STARVE_MAX)
                starve <= starve + 1'b1;
        end
    end

    // Sticky death flag, one cycle after the starvation count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dead <= 1'b0;
        else if (starve == STARVE_MAX)
            dead <= 1'b1;
    end

    assign energy_indicator = energy_level[W-1:W-2];
    assign stress_indicator = stress_level[W-1:W-2];

endmodule

// File: tb/tb_vital_level_tracker.sv
// Scoreboard bench for vital_level_tracker. The stimulus process pushes hand-computed
// expectations, and the monitor pops and compares them on the next falling edge.
module tb_vital_level_tracker;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en_inc, en_dec, st_dec, pl_inc, feed, stress_evt;
    logic [W-1:0] energy_level, stress_level, pleasure_level;
    logic [1:0]   energy_indicator, stress_indicator;
    logic         dead, tick;

    int checks   = 0;
    int failures = 0;

    localparam int S_EN = 0, S_ST = 1, S_PL = 2, S_EI = 3, S_SI = 4, S_DEAD = 5, S_TICK = 6;

    typedef struct {
        string name;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];

    vital_level_tracker #(
        .W(W), .TICK_DIV(16), .EN_INIT(192), .FEED_STEP(32), .ST_STEP(16), .DEAD_TICKS(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .en_inc(en_inc), .en_dec(en_dec), .st_dec(st_dec), .pl_inc(pl_inc),
        .feed(feed), .stress_evt(stress_evt),
        .energy_level(energy_level), .stress_level(stress_level),
        .pleasure_level(pleasure_level),
        .energy_indicator(energy_indicator), .stress_indicator(stress_indicator),
        .dead(dead), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic int get_out(input int sel);
        case (sel)
            S_EN:    return int'(energy_level);
            S_ST:    return int'(stress_level);
            S_PL:    return int'(pleasure_level);
            S_EI:    return int'(energy_indicator);
            S_SI:    return int'(stress_indicator);
            S_DEAD:  return int'(dead);
            default: return int'(tick);
        endcase
    endfunction

    // Monitor: drain every expectation queued since the last rising edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            int   act;
            e   = sb.pop_front();
            act = get_out(e.sel);
            checks++;
            if (act != e.val) begin
                failures++;
                $display("FAIL %s actual=%0d expected=%0d @%0t", e.name, act, e.val, $time);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input int val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return just after the edge on which tick goes high (bounded wait).
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 40);
        if (!tick) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout actual=0 expected=1 @%0t", $time);
        end
    endtask

    // Consume any pending tick so that new rate inputs start on a clean tick boundary.
    task automatic align();
        wait_tick();
        step();
    endtask

    task automatic expect_reset(input string tag);
        expect_val({tag, "_energy"}, S_EN, 192);
        expect_val({tag, "_eind"},   S_EI, 3);
        expect_val({tag, "_stress"}, S_ST, 0);
        expect_val({tag, "_sind"},   S_SI, 0);
        expect_val({tag, "_pleas"},  S_PL, 0);
        expect_val({tag, "_dead"},   S_DEAD, 0);
        expect_val({tag, "_tick"},   S_TICK, 0);
    endtask

    task automatic first_tick(input string tag);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) expect_val({tag, "_tick15"}, S_TICK, 0);
            if (i == 16) expect_val({tag, "_tick16"}, S_TICK, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {en_inc, en_dec, st_dec, pl_inc, feed, stress_evt} = '0;
        repeat (3) step();
        rst_n = 1'b1;
        expect_reset("rst");

        // 1: first tick at cycle 16, pleasure saturates low
        first_tick("t1");
        step();
        expect_val("t1_pleas_sat0", S_PL, 0);
        expect_val("t1_tick_off", S_TICK, 0);

        // 2: en_dec for 64 ticks, pleasure up meanwhile
        en_dec = 1'b1;
        pl_inc = 1'b1;
        wait_tick(); step();
        expect_val("t2_en191", S_EN, 191);
        expect_val("t2_eind191", S_EI, 2);
        expect_val("t2_pl1", S_PL, 1);
        repeat (63) wait_tick();
        step();
        en_dec = 1'b0;
        pl_inc = 1'b0;
        expect_val("t2_en128", S_EN, 128);
        expect_val("t2_eind128", S_EI, 2);
        expect_val("t2_pl64", S_PL, 64);

        // 3: feeds up to 224, en_inc to 250, then the clamp at 255
        for (int k = 1; k <= 3; k++) begin
            feed = 1'b1; step(); feed = 1'b0;
            expect_val("t3_feed", S_EN, 128 + 32 * k);
        end
        align();
        en_inc = 1'b1;
        repeat (26) wait_tick();
        step();
        en_inc = 1'b0;
        expect_val("t3_en250", S_EN, 250);
        expect_val("t3_eind250", S_EI, 3);
        feed = 1'b1; step(); feed = 1'b0;
        expect_val("t3_feed_clamp", S_EN, 255);
        feed = 1'b1; step(); feed = 1'b0;
        expect_val("t3_feed_clamp2", S_EN, 255);
        for (int k = 1; k <= 17; k++) begin
            stress_evt = 1'b1; step(); stress_evt = 1'b0;
            if (k == 1) begin
                expect_val("t3_st16", S_ST, 16);
                expect_val("t3_sind16", S_SI, 0);
            end
            if (k == 16) expect_val("t3_st_clamp16", S_ST, 255);
            if (k == 17) begin
                expect_val("t3_st_clamp17", S_ST, 255);
                expect_val("t3_sind255", S_SI, 3);
            end
            step();
        end
        align();
        st_dec = 1'b1;
        wait_tick(); step();
        st_dec = 1'b0;
        expect_val("t3_st_dec", S_ST, 254);

        // 4: drain to 100, then feed coinciding with tick and en_dec
        align();
        en_dec = 1'b1;
        repeat (155) wait_tick();
        step();
        expect_val("t4_en100", S_EN, 100);
        expect_val("t4_eind100", S_EI, 1);
        wait_tick();
        feed = 1'b1; step(); feed = 1'b0;
        expect_val("t4_feed_tick", S_EN, 131);
        expect_val("t4_eind131", S_EI, 2);

        // 5: starve to death, then confirm the freeze while dead
        repeat (131) wait_tick();
        step();
        expect_val("t5_en0", S_EN, 0);
        expect_val("t5_eind0", S_EI, 0);
        repeat (32) wait_tick();
        step();
        expect_val("t5_dead_pre", S_DEAD, 0);
        step();
        expect_val("t5_dead", S_DEAD, 1);
        en_dec = 1'b0; en_inc = 1'b1; pl_inc = 1'b1;
        feed = 1'b1; stress_evt = 1'b1;
        step();
        feed = 1'b0; stress_evt = 1'b0;
        wait_tick(); wait_tick(); step();
        expect_val("t5_frz_en", S_EN, 0);
        expect_val("t5_frz_st", S_ST, 254);
        expect_val("t5_frz_pl", S_PL, 0);
        expect_val("t5_dead_sticky", S_DEAD, 1);
        wait_tick();
        repeat (15) step();
        expect_val("t5_dead_tick15", S_TICK, 0);
        step();
        expect_val("t5_dead_tick16", S_TICK, 1);

        // 6: asynchronous reset with prescaler at 9 while dead
        repeat (9) step();
        {en_inc, en_dec, st_dec, pl_inc, feed, stress_evt} = '0;
        rst_n = 1'b0;
        expect_reset("t6");
        repeat (2) step();
        rst_n = 1'b1;
        first_tick("t6");
        step();

        // 5b: starve for 20 ticks, feed clears starve, no early death
        en_dec = 1'b1;
        repeat (192) wait_tick();
        step();
        expect_val("t5b_en0", S_EN, 0);
        repeat (20) wait_tick();
        step();
        feed = 1'b1; step(); feed = 1'b0;
        expect_val("t5b_fed", S_EN, 32);
        expect_val("t5b_alive", S_DEAD, 0);
        repeat (32) wait_tick();
        step();
        expect_val("t5b_en0_again", S_EN, 0);
        repeat (12) wait_tick();
        step(); step();
        expect_val("t5b_starve_cleared", S_DEAD, 0);
        repeat (20) wait_tick();
        step();
        expect_val("t5b_dead_pre", S_DEAD, 0);
        step();
        expect_val("t5b_dead", S_DEAD, 1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
